headgen_ucode_seq: RTL and testbench
====================================

HEADGEN_UCODE_SEQ -- requirements
Module: headgen_ucode_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of microcode-memory address and of header length.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to emit one header; sampled only in IDLE.
REQ-005 SHALL have port hdr_base  input  ADDR_W  microcode address of first header word.
REQ-006 SHALL have port hdr_len  input  ADDR_W  header length in bytes (1..2^ADDR_W-1).
REQ-007 SHALL have port dyn_in_0..dyn_in_3  input  8 each  live dynamic field sources.
REQ-008 SHALL have port busy  output  1  high while a header is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last byte handshake.
REQ-010 SHALL have port ucode_rd_en  output  1  microcode memory read strobe.
REQ-011 SHALL have port ucode_addr  output  ADDR_W  microcode memory read address.
REQ-012 SHALL have port ucode_data  input  9  read data, valid exactly 1 cycle after ucode_rd_en.
REQ-013 SHALL have port microcode_out  output  9  current word for the output mux core ({final_sel, static/select byte}).
REQ-014 SHALL have port dyndata_out_0..dyndata_out_3  output  8 each  dynamic fields frozen for the current header.
REQ-015 SHALL have port out_valid  output  1  microcode_out holds a valid header byte.
REQ-016 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-017 SHALL have ports out_sop / out_eop  output  1 each  first / last byte of header, qualified by out_valid.

Function
REQ-018 SHALL implement states IDLE and RUN; IDLE->RUN when start=1 and hdr_len!=0 in IDLE; RUN->IDLE on the eop transfer.
REQ-019 SHALL ignore start when hdr_len=0 (stay IDLE, no read, no done) and whenever state is RUN.
REQ-020 SHALL on start acceptance latch hdr_base, hdr_len and dyn_in_0..3 into dyndata_out_0..3, holding them constant until the next acceptance.
REQ-021 SHALL issue reads to addresses hdr_base+0 .. hdr_base+hdr_len-1 in order, each exactly once, address arithmetic modulo 2^ADDR_W (wrap past top).
REQ-022 SHALL buffer returned words in a 2-entry FIFO whose head drives microcode_out; out_valid = FIFO non-empty.
REQ-023 SHALL assert ucode_rd_en in a RUN cycle only if reads issued < hdr_len and (FIFO count + reads in flight - pop this cycle) < 2, so the FIFO never overflows.
REQ-024 SHALL, with start accepted at cycle T and out_ready held 1, drive first ucode_rd_en in T+1, first out_valid (with out_sop) in T+3, and one byte per cycle thereafter, out_eop in T+2+hdr_len.
REQ-025 SHALL keep microcode_out, out_sop, out_eop stable while out_valid=1 and out_ready=0.
REQ-026 SHALL assert out_sop only on the first byte and out_eop only on byte hdr_len; hdr_len=1 gives sop and eop on the same byte.
REQ-027 SHALL drive busy=1 from the cycle after acceptance through the eop transfer cycle, done=1 in the following cycle with busy=0, and SHALL accept a new start in that same done cycle.
REQ-028 SHALL hold ucode_rd_en=0 and out_valid=0 in IDLE; ucode_addr value is don't-care when ucode_rd_en=0.

Reset
REQ-029 SHALL on rst=1 immediately force IDLE, empty FIFO, zero in-flight count, busy=0, done=0, ucode_rd_en=0, out_valid=0, out_sop=0, out_eop=0, microcode_out=0, dyndata_out_0..3=0, ucode_addr=0.
REQ-030 SHALL on reset asserted mid-header abandon the header with no eop and no done, and discard any read data returning after reset release.

Verification
REQ-031 SHALL cover: hdr_base=0x10, hdr_len=4, out_ready=1 -> reads 0x10..0x13 in T+1..T+4, bytes T+3..T+6, sop at T+3, eop at T+6, done at T+7.
REQ-032 SHALL cover: hdr_len=6, out_ready toggling 1,0,0,1 -> all 6 words delivered in order, no duplicates/drops, never more than 2 outstanding words, outputs stable while stalled.
REQ-033 SHALL cover: hdr_base=0x3E, hdr_len=4, ADDR_W=6 -> addresses 0x3E,0x3F,0x00,0x01.
REQ-034 SHALL cover: hdr_len=1 -> single byte with sop=eop=1; hdr_len=0 start -> no read, busy stays 0, no done.
REQ-035 SHALL cover: start held high through header and done cycle, dyn_in changing mid-header -> dyndata_out constant per header, back-to-back header starts in the done cycle, start during RUN ignored.
REQ-036 SHALL cover: rst pulsed after 2 of 5 bytes -> all outputs at reset values same cycle, no eop/done, next header starts clean with sop on its first byte.

Source files
------------

// File: rtl/headgen_ucode_seq.sv
// Header generator sequencer: fetches hdr_len microcode words starting at
// hdr_base, buffers them in a 2-entry FIFO and streams them out under a
// valid/ready handshake, with per-header frozen dynamic field values.
module headgen_ucode_seq #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] hdr_base,
  input  logic [ADDR_W-1:0] hdr_len,
  input  logic [7:0]        dyn_in_0,
  input  logic [7:0]        dyn_in_1,
  input  logic [7:0]        dyn_in_2,
  input  logic [7:0]        dyn_in_3,
  output logic              busy,
  output logic              done,
  output logic              ucode_rd_en,
  output logic [ADDR_W-1:0] ucode_addr,
  input  logic [8:0]        ucode_data,
  output logic [8:0]        microcode_out,
  output logic [7:0]        dyndata_out_0,
  output logic [7:0]        dyndata_out_1,
  output logic [7:0]        dyndata_out_2,
  output logic [7:0]        dyndata_out_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  localparam int unsigned WORD_W = 9;
  localparam int unsigned DYN_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic [ADDR_W-1:0]   popped_q, popped_d;
  logic [WORD_W-1:0]   fifo_q [2];
  logic [WORD_W-1:0]   fifo_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic                done_q, done_d;
  logic [DYN_W-1:0]    dyn_q [4];
  logic [DYN_W-1:0]    dyn_d [4];

  logic                accept;
  logic                pop;
  logic                push;
  logic                rd_en;
  logic                eop_xfer;
  logic [2:0]          occ;

  // Output decode straight from state registers
  assign out_valid     = (cnt_q != 2'd0);
  assign out_sop       = out_valid && (popped_q == '0);
  assign out_eop       = out_valid && (popped_q == (len_q - ADDR_W'(1)));
  assign microcode_out = fifo_q[rd_ptr_q];
  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign ucode_addr    = addr_q;
  assign ucode_rd_en   = rd_en;
  assign dyndata_out_0 = dyn_q[0];
  assign dyndata_out_1 = dyn_q[1];
  assign dyndata_out_2 = dyn_q[2];
  assign dyndata_out_3 = dyn_q[3];

  // Handshake and read-issue decisions; a pop this cycle frees a slot so reads can stream back to back
  always_comb begin
    accept   = (state_q == IDLE) && start && (hdr_len != '0);
    pop      = out_valid && out_ready;
    push     = inflight_q;
    eop_xfer = pop && out_eop;
    occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    rd_en    = (state_q == RUN) && (issued_q != len_q) && (occ < 3'd2);
  end

  // Next-state computation for FSM, read pointer, FIFO and frozen fields
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    inflight_d = rd_en;
    done_d     = eop_xfer;
    dyn_d      = dyn_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          addr_d   = hdr_base;
          len_d    = hdr_len;
          issued_d = '0;
          popped_d = '0;
          dyn_d[0] = dyn_in_0;
          dyn_d[1] = dyn_in_1;
          dyn_d[2] = dyn_in_2;
          dyn_d[3] = dyn_in_3;
        end
      end
      RUN: begin
        if (eop_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_en) begin
      addr_d   = addr_q + ADDR_W'(1);
      issued_d = issued_q + ADDR_W'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = ucode_data;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      popped_d = popped_q + ADDR_W'(1);
    end

    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  // State registers; reset abandons any header and drops in-flight read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      dyn_q[0]   <= '0;
      dyn_q[1]   <= '0;
      dyn_q[2]   <= '0;
      dyn_q[3]   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      dyn_q      <= dyn_d;
    end
  end

endmodule

// File: tb/tb_headgen_ucode_seq.sv
// Self-checking bench for headgen_ucode_seq with a behavioural memory and
// an expected byte stream derived from base/len and the memory contents.
module tb_headgen_ucode_seq;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] hdr_base;
  logic [ADDR_W-1:0] hdr_len;
  logic [7:0]        dyn_in_0, dyn_in_1, dyn_in_2, dyn_in_3;
  logic              busy, done, ucode_rd_en;
  logic [ADDR_W-1:0] ucode_addr;
  logic [8:0]        ucode_data;
  logic [8:0]        microcode_out;
  logic [7:0]        dyndata_out_0, dyndata_out_1, dyndata_out_2, dyndata_out_3;
  logic              out_valid, out_ready, out_sop, out_eop;

  logic [8:0]        mem [DEPTH];
  int                n_cmp;
  int                n_err;

  headgen_ucode_seq #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .hdr_base(hdr_base), .hdr_len(hdr_len),
    .dyn_in_0(dyn_in_0), .dyn_in_1(dyn_in_1), .dyn_in_2(dyn_in_2), .dyn_in_3(dyn_in_3),
    .busy(busy), .done(done), .ucode_rd_en(ucode_rd_en), .ucode_addr(ucode_addr),
    .ucode_data(ucode_data), .microcode_out(microcode_out),
    .dyndata_out_0(dyndata_out_0), .dyndata_out_1(dyndata_out_1),
    .dyndata_out_2(dyndata_out_2), .dyndata_out_3(dyndata_out_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory with one-cycle read latency
  always @(posedge clk) begin
    if (ucode_rd_en) ucode_data <= mem[ucode_addr];
  end

  // Runs one header and checks reads, bytes, flags, stalls, busy/done and frozen fields
  task automatic run_header(input logic [ADDR_W-1:0] base, input int len, input int mode,
                            input bit hold, input bit b2b, input bit chk_t);
    logic [7:0]        dx0, dx1, dx2, dx3;
    logic [ADDR_W-1:0] ea;
    logic [8:0]        pv_d;
    logic              pv_s, pv_e;
    int reads, bytes, c, first_rd, first_byte, eop_c;
    bit fin, stall_prev;
    if (!b2b) @(negedge clk);
    start    = 1'b1;
    hdr_base = base;
    hdr_len  = ADDR_W'(len);
    dx0 = 8'($urandom); dx1 = 8'($urandom); dx2 = 8'($urandom); dx3 = 8'($urandom);
    dyn_in_0 = dx0; dyn_in_1 = dx1; dyn_in_2 = dx2; dyn_in_3 = dx3;
    @(posedge clk);
    reads = 0; bytes = 0; c = 0; first_rd = -1; first_byte = -1; eop_c = -1;
    fin = 0; stall_prev = 0; pv_d = '0; pv_s = 0; pv_e = 0;
    while (!fin && c < 400) begin
      @(negedge clk);
      c++;
      start = hold;
      if (hold) begin
        hdr_base = ADDR_W'($urandom);
        hdr_len  = ADDR_W'($urandom);
      end
      dyn_in_0 = 8'($urandom); dyn_in_1 = 8'($urandom);
      dyn_in_2 = 8'($urandom); dyn_in_3 = 8'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (eop_c >= 0) begin
        n_cmp++;
        if ({done, busy, out_valid, ucode_rd_en} !== 4'b1000) begin
          n_err++;
          $display("FAIL done_cycle: got done/busy/valid/rd=%b want 1000", {done, busy, out_valid, ucode_rd_en});
        end
        fin = 1;
      end else begin
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
          n_err++;
          $display("FAIL busy_run c=%0d: got busy/done=%b want 10", c, {busy, done});
        end
        n_cmp++;
        if ({dyndata_out_0, dyndata_out_1, dyndata_out_2, dyndata_out_3} !== {dx0, dx1, dx2, dx3}) begin
          n_err++;
          $display("FAIL dyndata c=%0d: got %h want %h", c,
                   {dyndata_out_0, dyndata_out_1, dyndata_out_2, dyndata_out_3}, {dx0, dx1, dx2, dx3});
        end
        n_cmp++;
        if (reads - bytes > 2) begin
          n_err++;
          $display("FAIL outstanding c=%0d: got %0d want <=2", c, reads - bytes);
        end
        if (ucode_rd_en) begin
          ea = base + ADDR_W'(reads);
          n_cmp++;
          if (ucode_addr !== ea || reads >= len) begin
            n_err++;
            $display("FAIL rd_addr c=%0d: got %h (read #%0d) want %h (of %0d)", c, ucode_addr, reads, ea, len);
          end
          if (first_rd < 0) first_rd = c;
          reads++;
        end
        if (stall_prev) begin
          n_cmp++;
          if ({out_valid, microcode_out, out_sop, out_eop} !== {1'b1, pv_d, pv_s, pv_e}) begin
            n_err++;
            $display("FAIL stall_stable c=%0d: got %b want %b", c,
                     {out_valid, microcode_out, out_sop, out_eop}, {1'b1, pv_d, pv_s, pv_e});
          end
        end
        stall_prev = 0;
        if (out_valid) begin
          if (out_ready) begin
            ea = base + ADDR_W'(bytes);
            n_cmp++;
            if ({microcode_out, out_sop, out_eop} !== {mem[ea], 1'(bytes == 0), 1'(bytes == len - 1)}) begin
              n_err++;
              $display("FAIL byte%0d: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b", bytes,
                       microcode_out, out_sop, out_eop, mem[ea], bytes == 0, bytes == len - 1);
            end
            if (first_byte < 0) first_byte = c;
            if (bytes == len - 1) eop_c = c;
            bytes++;
          end else begin
            stall_prev = 1;
            pv_d = microcode_out; pv_s = out_sop; pv_e = out_eop;
          end
        end
      end
    end
    n_cmp++;
    if (!fin || reads != len || bytes != len) begin
      n_err++;
      $display("FAIL header_end: got fin=%0d reads=%0d bytes=%0d want 1/%0d/%0d", fin, reads, bytes, len, len);
    end
    if (chk_t) begin
      n_cmp++;
      if (first_rd != 1 || first_byte != 3 || eop_c != 2 + len) begin
        n_err++;
        $display("FAIL timing: got rd=%0d byte=%0d eop=%0d want 1/3/%0d", first_rd, first_byte, eop_c, 2 + len);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({busy, done, ucode_rd_en, out_valid, out_sop, out_eop, microcode_out} !== 15'd0 ||
        {dyndata_out_0, dyndata_out_1, dyndata_out_2, dyndata_out_3} !== 32'd0 || ucode_addr !== '0) begin
      n_err++;
      $display("FAIL %s: got ctl=%b mc=%h dyn=%h addr=%h want all zero", tag,
               {busy, done, ucode_rd_en, out_valid, out_sop, out_eop}, microcode_out,
               {dyndata_out_0, dyndata_out_1, dyndata_out_2, dyndata_out_3}, ucode_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; hdr_base = '0; hdr_len = '0;
    dyn_in_0 = '0; dyn_in_1 = '0; dyn_in_2 = '0; dyn_in_3 = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_header(6'h10, 4, 0, 0, 0, 1);
  endtask

  task automatic test_stall();
    run_header(6'h05, 6, 1, 0, 0, 0);
  endtask

  task automatic test_wrap();
    run_header(6'h3E, 4, 0, 0, 0, 1);
  endtask

  task automatic test_short_len();
    run_header(ADDR_W'($urandom), 1, 0, 0, 0, 1);
    @(negedge clk);
    start = 1'b1; hdr_len = '0; hdr_base = ADDR_W'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({ucode_rd_en, busy, done, out_valid} !== 4'b0000) begin
        n_err++;
        $display("FAIL len0 cyc%0d: got rd/busy/done/valid=%b want 0000", i, {ucode_rd_en, busy, done, out_valid});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_header(ADDR_W'($urandom), 5, 0, 1, 0, 1);
    run_header(ADDR_W'($urandom), 3, 0, 1, 1, 1);
    run_header(ADDR_W'($urandom), 7, 2, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    int bytes, c;
    @(negedge clk);
    start = 1'b1; hdr_base = ADDR_W'($urandom); hdr_len = 6'd5; out_ready = 1'b1;
    @(posedge clk);
    bytes = 0; c = 0;
    while (bytes < 2 && c < 20) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      #1;
      if (out_valid && out_ready) bytes++;
    end
    n_cmp++;
    if (bytes != 2) begin
      n_err++;
      $display("FAIL rst_mid_progress: got %0d bytes want 2", bytes);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid_same_cycle");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_eop, busy, done, ucode_rd_en} !== 5'b00000) begin
        n_err++;
        $display("FAIL rst_mid_after cyc%0d: got valid/eop/busy/done/rd=%b want 00000", i,
                 {out_valid, out_eop, busy, done, ucode_rd_en});
      end
    end
    run_header(ADDR_W'($urandom), 5, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_header(ADDR_W'($urandom), int'($urandom_range(1, 20)), 2, 1'($urandom_range(0, 1)), i[0], 0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ucode_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 9'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_short_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
